// File: rtl/ram_wishbone_ws.sv
// Wishbone classic-cycle data RAM with byte lanes, base-address decode,
// error termination for out-of-range/misaligned accesses and configurable wait states.
module ram_wishbone_ws #(
  parameter int unsigned SIZE        = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [3:0]  SEL_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);

  localparam int unsigned WORDS    = SIZE / 4;
  localparam int unsigned IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W    = 4;
  localparam logic [31:0] LAST_OFF = 32'(SIZE - 4);
  localparam logic [CNT_W-1:0] WS_LOAD = CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam bit          NO_WAIT  = (WAIT_STATES == 0);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Word-organised storage; zeroed at elaboration, never cleared by reset.
  logic [31:0] mem [WORDS] = '{default: '0};

  logic [31:0]      off;
  logic [IDX_W-1:0] idx;
  logic             bad;
  logic             req;
  logic             go_resp;

  // Below-base addresses wrap to huge offsets and fail the range test.
  assign off = ADR_I - BASE_ADDR;
  assign bad = (ADR_I[1:0] != 2'b00) || (off > LAST_OFF);
  assign idx = off[IDX_W+1:2];
  assign req = CYC_I && STB_I;

  // Edge on which the access completes and RESP is entered.
  assign go_resp = ((state == IDLE) && req && (bad || NO_WAIT)) ||
                   ((state == WAIT) && CYC_I && (cnt == '0));

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state <= IDLE;
      cnt   <= '0;
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK_O <= 1'b0;
      ERR_O <= 1'b0;
      if (go_resp) begin
        state <= RESP;
        if (bad) begin
          ERR_O <= 1'b1;
          DAT_O <= '0;
        end else begin
          ACK_O <= 1'b1;
          if (!WE_I) begin
            DAT_O <= mem[idx];
          end
        end
      end else begin
        case (state)
          IDLE: begin
            if (req) begin
              state <= WAIT;
              cnt   <= WS_LOAD;
            end
          end
          WAIT: begin
            if (!CYC_I) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - CNT_W'(1);
            end
          end
          RESP:    state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Byte-lane write, only on a good completing write outside reset.
  always_ff @(posedge CLK_I) begin
    if (!RST_I && go_resp && !bad && WE_I) begin
      for (int n = 0; n < 4; n++) begin
        if (SEL_I[n]) begin
          mem[idx][8*n +: 8] <= DAT_I[8*n +: 8];
        end
      end
    end
  end

endmodule

// File: doc/ram_wishbone_ws.md
Name: ram_wishbone_ws

Overview:
- Parametrised Wishbone classic-cycle data RAM; successor to the team's single-cycle byte-array RAM.
- Adds CYC_I/ACK_O/ERR_O handshake, per-byte write lanes (SEL_I), base-address decode, range/alignment error response, configurable wait states and a registered read port.
- Sits on the SoC data bus behind the interconnect; the CPU load/store unit is the only master.

Parameters:
- SIZE, 1024, memory size in bytes; multiple of 4, minimum 4.
- BASE_ADDR, 32'h0000_0000, byte address mapped to memory offset 0.
- WAIT_STATES, 0, extra cycles inserted before ACK_O; legal range 0..15.

Ports:
- CLK_I  in  1  clock, rising edge.
- RST_I  in  1  reset.
- CYC_I  in  1  bus cycle active.
- STB_I  in  1  strobe; request valid when CYC_I & STB_I.
- WE_I  in  1  1 = write, 0 = read.
- SEL_I  in  4  byte lane enables; bit n covers DAT_I/DAT_O[8n+7:8n].
- ADR_I  in  32  byte address.
- DAT_I  in  32  write data.
- DAT_O  out  32  registered read data.
- ACK_O  out  1  normal termination, one-cycle pulse.
- ERR_O  out  1  error termination, one-cycle pulse.

Behaviour:
- Interface: one clock (CLK_I); reset RST_I is synchronous and active-high.
- Reset: state=IDLE, wait counter=0, ACK_O=0, ERR_O=0, DAT_O=32'h0. Memory contents are not cleared by reset; they are zero-initialised at elaboration only.
- Reset mid-operation: the pending access is dropped (no write, no ACK_O/ERR_O).
- Decode:
  - off = ADR_I - BASE_ADDR, 32-bit unsigned wrap.
  - bad = (ADR_I[1:0] != 0) | (off > SIZE-4).
  - An address below BASE_ADDR wraps to a large offset and is therefore bad.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - A request (CYC_I & STB_I) sampled at a rising edge moves to RESP if bad or WAIT_STATES==0.
  - Otherwise it moves to WAIT with cnt = WAIT_STATES-1.
  - STB_I with CYC_I low is ignored.
- WAIT:
  - CYC_I low means abort: go to IDLE, no write, no ACK_O.
  - Otherwise, cnt==0 moves to RESP; else cnt decrements.
- Edge entering RESP:
  - bad: set ERR_O=1, DAT_O=0, no memory change.
  - Good write: mem[off+n] <= DAT_I[8n+7:8n] for each SEL_I[n]=1. DAT_O is unchanged.
  - Good read: DAT_O <= {mem[off+3], mem[off+2], mem[off+1], mem[off]} (little-endian, all 4 lanes, SEL_I ignored). Then ACK_O=1.
  - SEL_I=4'b0000 write: legal no-op, ACK_O still asserted.
- RESP: ACK_O or ERR_O is high for exactly this cycle; never both. Always returns to IDLE.
- Latency: ACK_O/ERR_O is high in the cycle starting WAIT_STATES+1 edges after the request is first sampled. Bad accesses always take 1 cycle.
- Minimum back-to-back period is WAIT_STATES+2 cycles.
- Master rules: hold ADR_I/WE_I/SEL_I/DAT_I stable from request until ACK_O/ERR_O. The master must drop STB_I, or present a new request, after termination. The RESP cycle never samples a request.
- DAT_O holds the last read value between reads; it is only defined while ACK_O=1 with WE_I=0.

Test Plan:
- Reset/idle: assert RST_I 2 cycles, then idle with CYC_I=0 -> ACK_O=0, ERR_O=0, DAT_O=0; read of 0x10 with WAIT_STATES=0 -> ACK_O high 1 cycle after sampling, DAT_O=0.
- Byte lanes: write 0x11223344 SEL=1111 to 0x20, then write 0xAABBCCDD SEL=0101 to 0x20, then read 0x20 -> DAT_O=0x11BB33DD.
- Wait states: WAIT_STATES=3, read 0x0 -> ACK_O asserted exactly 4 cycles after request sampled, single-cycle pulse; back-to-back reads spaced 5 cycles.
- Errors: BASE_ADDR=0x1000, SIZE=1024. Read 0x1002 -> ERR_O, DAT_O=0. Write 0x1400 -> ERR_O, memory unchanged. Read 0x0FFC -> ERR_O. Read 0x13FC -> ACK_O.
- Abort/reset: WAIT_STATES=5, write 0xDEADBEEF to BASE_ADDR, drop CYC_I after 2 cycles -> no ACK_O, and a later read returns the old data. Repeat with RST_I pulsed mid-WAIT -> same result, state IDLE, DAT_O=0.
